// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised UART receiver (data width, parity, stop bits, baud).
// Double-flop synchroniser, 3-sample mid-bit majority vote, start-glitch rejection,
// parity and framing error pulses.
// Ports:
//   sys_clk    - system clock, all logic rising-edge
//   rst        - asynchronous active-high reset
//   rx         - serial line, idle high, LSB first, asynchronous to sys_clk
//   data_out   - last received data word, held until the next good frame
//   valid_flag - one-cycle pulse, data_out valid
//   parity_err - one-cycle pulse with valid_flag on parity mismatch
//   frame_err  - one-cycle pulse when a stop bit is sampled low
//   busy       - high while the receiver is not idle
module uart_rx_param #(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD      = 9600,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 sys_clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 valid_flag,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int CPB   = CLK_FREQ / BAUD;
  localparam int HALF  = CPB / 2;
  localparam int CNT_W = $clog2(CPB);
  localparam int IDX_W = $clog2(DATA_BITS + 1);

  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(CPB - 1);
  localparam logic [CNT_W-1:0] C_S0   = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] C_S1   = CNT_W'(HALF);
  localparam logic [CNT_W-1:0] C_DEC  = CNT_W'(HALF + 1);
  localparam logic [IDX_W-1:0] I_DATA = IDX_W'(DATA_BITS);
  localparam logic [IDX_W-1:0] I_STOP = IDX_W'(STOP_BITS - 1);
  localparam logic             ODD    = (PARITY == 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
  } state_t;

  state_t                 r_state;
  state_t                 w_next;
  logic                   r_s1, r_s2, r_s2_d;
  logic [CNT_W-1:0]       r_cnt;
  logic [IDX_W-1:0]       r_idx;
  logic                   r_smp0, r_smp1;
  logic [DATA_BITS-1:0]   r_shift;
  logic                   r_perr;
  logic [DATA_BITS-1:0]   r_data;
  logic                   r_valid, r_perr_o, r_ferr;

  logic w_fall, w_dec, w_wrap, w_maj;
  logic w_valid_set, w_ferr_set, w_perr_set, w_busy;

  assign w_fall = r_s2_d & ~r_s2;
  assign w_dec  = (r_cnt == C_DEC);
  assign w_wrap = (r_cnt == C_LAST);
  // Third sample is the live synchronised value at the decision count.
  assign w_maj  = (r_smp0 & r_smp1) | (r_smp0 & r_s2) | (r_smp1 & r_s2);

  // State register
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_fall) w_next = S_START;
      S_START: begin
        if (w_dec && w_maj) w_next = S_IDLE;
        else if (w_wrap)    w_next = S_DATA;
      end
      S_DATA:   if (w_wrap && (r_idx == I_DATA))
                  w_next = (PARITY != 0) ? S_PARITY : S_STOP;
      S_PARITY: if (w_wrap) w_next = S_STOP;
      S_STOP: begin
        if (w_dec) begin
          if (!w_maj)                w_next = S_BREAK;
          else if (r_idx == I_STOP)  w_next = S_IDLE;
        end
      end
      S_BREAK:  if (r_s2) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Output / event decode
  always_comb begin
    w_valid_set = 1'b0;
    w_ferr_set  = 1'b0;
    w_perr_set  = 1'b0;
    w_busy      = (r_state != S_IDLE);
    if (r_state == S_STOP && w_dec) begin
      w_ferr_set  = ~w_maj;
      w_valid_set = w_maj & (r_idx == I_STOP);
    end
    if (r_state == S_PARITY && w_dec)
      w_perr_set = ((^r_shift) ^ w_maj) != ODD;
  end

  // Datapath: synchroniser, bit timer, sampling, shift register, output pulses
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      r_s1     <= 1'b1;
      r_s2     <= 1'b1;
      r_s2_d   <= 1'b1;
      r_cnt    <= '0;
      r_idx    <= '0;
      r_smp0   <= 1'b1;
      r_smp1   <= 1'b1;
      r_shift  <= '0;
      r_perr   <= 1'b0;
      r_data   <= '0;
      r_valid  <= 1'b0;
      r_perr_o <= 1'b0;
      r_ferr   <= 1'b0;
    end else begin
      r_s1   <= rx;
      r_s2   <= r_s1;
      r_s2_d <= r_s2;

      // Timer holds at 0 in IDLE so the first START cycle is count 0.
      if (r_state == S_IDLE || w_next == S_IDLE || w_next == S_BREAK || w_wrap)
        r_cnt <= '0;
      else
        r_cnt <= r_cnt + 1'b1;

      if (r_cnt == C_S0) r_smp0 <= r_s2;
      if (r_cnt == C_S1) r_smp1 <= r_s2;

      // idx counts data bits in DATA and stop bits in STOP.
      if (w_next != r_state)
        r_idx <= '0;
      else if (w_dec && (r_state == S_DATA || r_state == S_STOP))
        r_idx <= r_idx + 1'b1;

      if (w_dec && r_state == S_DATA)
        r_shift <= {w_maj, r_shift[DATA_BITS-1:1]};

      if (r_state == S_IDLE) r_perr <= 1'b0;
      else if (w_perr_set)   r_perr <= 1'b1;

      r_valid  <= w_valid_set;
      r_ferr   <= w_ferr_set;
      r_perr_o <= w_valid_set & r_perr;
      if (w_valid_set) r_data <= r_shift;
    end
  end

  assign data_out   = r_data;
  assign valid_flag = r_valid;
  assign parity_err = r_perr_o;
  assign frame_err  = r_ferr;
  assign busy       = w_busy;

endmodule
